ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
Parametrised instruction-fetch unit that replaces the fixed pc+4 register and combinational instruction read with a decoupled front end.
- Holds the fetch PC and issues one outstanding request at a time over a valid/ready memory channel.
- Accepts branch/jump redirects from execute and discards stale responses.
- Buffers fetched instructions in a queue feeding decode with a valid/ready handshake.

Parameters:
XLEN, 64, address/PC width
ILEN, 32, instruction width
RESET_PC, 64'h0000000080000000, fetch PC after reset
FQ_DEPTH, 4, fetch-queue entries (power of 2, >= 2)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset; asynchronous assert, active-low
redirect_valid  in  1  execute requests fetch restart
redirect_pc  in  XLEN  new fetch PC
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address
imem_resp_valid  in  1  response valid (always accepted)
imem_resp_data  in  ILEN  fetched instruction
imem_resp_err  in  1  access fault on this response
inst_valid  out  1  queue head valid
inst_ready  in  1  decode consumes head
inst  out  ILEN  head instruction
inst_pc  out  XLEN  head PC
inst_fault  out  2  head fault: 0 none, 1 access, 2 misaligned

Behaviour:
- Reset (rst_n=0):
  - state=IDLE, fetch_pc=RESET_PC.
  - Queue empty, pointers/count=0.
  - imem_req_valid=0, inst_valid=0, inst/inst_pc/inst_fault=0.
- FSM states IDLE, REQ, WAIT, DROP, HALT:
  - IDLE: next cycle -> REQ.
  - REQ:
    - If fetch_pc[1:0]!=0 and count<FQ_DEPTH: push {inst=0, pc=fetch_pc, fault=2}, no request, -> HALT.
    - Else imem_req_valid=(count<FQ_DEPTH), imem_req_addr=fetch_pc.
    - On handshake: latch req_pc=fetch_pc, fetch_pc+=4 (mod 2^XLEN), -> WAIT.
  - WAIT: on imem_resp_valid: push {resp_data, req_pc, fault=resp_err?1:0} -> REQ. Zero-latency responses are not allowed; earliest response is the cycle after the handshake.
  - DROP: on imem_resp_valid: discard -> REQ.
  - HALT: no requests until redirect.
- Request rules: addr stable while valid&&!ready, except on redirect (request may be withdrawn/retargeted). One request is outstanding at most.
- Redirect (priority over everything):
  - Queue flushes (count=0), fetch_pc<=redirect_pc. inst_valid=0 the following cycle; a pop the same cycle is ignored.
  - REQ without handshake -> REQ. REQ with handshake same cycle -> DROP (request used old PC).
  - WAIT without resp -> DROP. WAIT with resp same cycle: response discarded -> REQ.
  - DROP -> DROP. HALT or IDLE -> REQ.
- Queue:
  - Circular FIFO, log2(FQ_DEPTH)-bit pointers wrapping modulo depth, count 0..FQ_DEPTH.
  - Head outputs are registered-array reads, so a push is visible on inst_valid next cycle.
  - Simultaneous push and pop: count unchanged.
  - Push when full cannot occur (request gated by count<FQ_DEPTH, single outstanding).
- Reset mid-operation: all state returns to reset values immediately. Any later response is ignored in IDLE/REQ.

Decomposition:
- Package ifu_pkg: fetch-state enum, fault-code constants (FAULT_NONE/ACCESS/MISALIGN), queue-entry typedef {inst, pc, fault}, default RESET_PC constant.
- Sub-module fetch_queue (parametrised FIFO of entries with push, pop, flush, count, full/empty). The FSM and PC register stay in ifu_fetch.

Test Plan:
- Reset release, memory always ready, 1-cycle response, inst_ready=1 -> requests 0x80000000, 0x80000004, 0x80000008; inst_pc in same order with data returned, inst_fault=0.
- inst_ready=0 -> exactly FQ_DEPTH=4 entries queued, imem_req_valid drops while count=4. One pop -> exactly one new request.
- Redirect to 0x80001000 during WAIT, response arrives 2 cycles later -> response dropped, next request addr 0x80001000, queue empty the cycle after redirect.
- Redirect to 0x80000202 -> no memory request, one entry inst_pc=0x80000202, inst_fault=2, then HALT. Redirect to 0x80000400 resumes fetching.
- Response with imem_resp_err=1 at 0x80000004 -> entry inst_fault=1, inst_pc=0x80000004, fetching continues at 0x80000008.
- imem_req_ready=0 for 3 cycles -> imem_req_addr held at 0x80000000. rst_n pulsed low mid-WAIT -> outputs zero immediately, restart at RESET_PC.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit.
//   fetch_state_e : fetch sequencer states
//   FAULT_*       : fault codes carried with each fetched instruction
//   fq_entry_t    : fetch-queue entry at the default widths (32-bit inst, 64-bit pc)
package ifu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DROP,
    ST_HALT
  } fetch_state_e;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_ACCESS   = 2'd1;
  localparam logic [1:0] FAULT_MISALIGN = 2'd2;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [1:0]  fault;
  } fq_entry_t;

endpackage

// File: rtl/ifu_fetch_queue.sv
// Circular FIFO of fetched instructions between the fetch sequencer and decode.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   push, push_data     write one entry (ignored when full)
//   pop                 consume the head entry (ignored when empty)
//   flush               drop all entries; wins over push and pop
//   head                registered head entry, zero when empty
//   count, full, empty  occupancy
module fetch_queue
  import ifu_pkg::*;
#(
  parameter type entry_t = fq_entry_t,
  parameter int  DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  input  logic                     flush,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push;
  logic            do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  // Gate the head so an empty queue presents zeros rather than stale data.
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Decoupled instruction-fetch front end: owns the fetch PC, keeps at most one
// request outstanding on the imem channel, applies execute redirects and
// buffers fetched instructions for decode.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   redirect_valid, redirect_pc         restart fetch at a new PC
//   imem_req_valid/ready/addr           request channel
//   imem_resp_valid/data/err            response channel (always accepted)
//   inst_valid/ready, inst, inst_pc,    decode channel (queue head)
//   inst_fault                          0 none, 1 access, 2 misaligned
//
// state | meaning
// IDLE  | first cycle after reset, no request yet
// REQ   | presenting a request for fetch_pc (or trapping a misaligned PC)
// WAIT  | request accepted, waiting for its response
// DROP  | redirected while a request was in flight; discard its response
// HALT  | misaligned PC reported; idle until the next redirect
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int               XLEN     = 64,
  parameter int               ILEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = DEFAULT_RESET_PC[XLEN-1:0],
  parameter int               FQ_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_resp_valid,
  input  logic [ILEN-1:0]  imem_resp_data,
  input  logic             imem_resp_err,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [ILEN-1:0]  inst,
  output logic [XLEN-1:0]  inst_pc,
  output logic [1:0]       inst_fault
);

  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [1:0]      fault;
  } entry_t;

  fetch_state_e     state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  req_pc_q, req_pc_d;

  logic             req_valid;
  logic             req_fire;
  logic             fq_push;
  entry_t           fq_push_data;
  entry_t           fq_head;
  logic [CNT_W-1:0] fq_count;
  logic             fq_full;
  logic             fq_empty;

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = req_valid && imem_req_ready;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    req_valid    = 1'b0;
    fq_push      = 1'b0;
    fq_push_data = '0;

    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (fetch_pc_q[1:0] != 2'b00) begin
          // Report the bad PC through the queue instead of issuing a request.
          if (!fq_full) begin
            fq_push      = 1'b1;
            fq_push_data = '{inst: '0, pc: fetch_pc_q, fault: FAULT_MISALIGN};
            state_d      = ST_HALT;
          end
        end else begin
          // A free slot is guaranteed for the response since only one
          // request is ever in flight.
          req_valid = !fq_full;
          if (req_valid && imem_req_ready) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            state_d    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (imem_resp_valid) begin
          fq_push      = 1'b1;
          fq_push_data = '{inst:  imem_resp_data,
                           pc:    req_pc_q,
                           fault: imem_resp_err ? FAULT_ACCESS : FAULT_NONE};
          state_d      = ST_REQ;
        end
      end
      ST_DROP: begin
        if (imem_resp_valid) begin
          state_d = ST_REQ;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      fq_push    = 1'b0;
      case (state_q)
        ST_REQ:  state_d = req_fire ? ST_DROP : ST_REQ;
        ST_WAIT: state_d = imem_resp_valid ? ST_REQ : ST_DROP;
        ST_DROP: state_d = ST_DROP;
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  fetch_queue #(
    .entry_t (entry_t),
    .DEPTH   (FQ_DEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fq_push),
    .push_data (fq_push_data),
    .pop       (inst_ready),
    .flush     (redirect_valid),
    .head      (fq_head),
    .count     (fq_count),
    .full      (fq_full),
    .empty     (fq_empty)
  );

  assign inst_valid = !fq_empty;
  assign inst       = fq_head.inst;
  assign inst_pc    = fq_head.pc;
  assign inst_fault = fq_head.fault;

  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    fq_count <= CNT_W'(FQ_DEPTH));

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic [1:0]  inst_fault;

  ifu_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_fault      (inst_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [1:0]  fault;
  } exp_t;

  exp_t        exp_inst[$];
  logic [63:0] exp_req[$];
  exp_t        mon_e;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          hs_total = 0;   // accepted requests, written only by the memory model
  int          hs_limit = 0;   // memory accepts requests while hs_total < hs_limit
  int          lat      = 1;   // response latency in cycles after the handshake
  logic [63:0] err_addr = '1;

  logic [63:0] p_addr = '0;
  int          p_cnt  = 0;
  bit          pend   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, expv);
    end
  endtask

  function automatic void add_inst(input logic [31:0] d, input logic [63:0] pc,
                                   input logic [1:0] f);
    exp_t e;
    e.inst  = d;
    e.pc    = pc;
    e.fault = f;
    exp_inst.push_back(e);
  endfunction

  // Memory model: returns addr[31:0] + 0x1000_0000 after 'lat' cycles.
  initial begin
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    imem_resp_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && imem_req_valid && imem_req_ready) begin
        if (exp_req.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_req: actual addr=%h required none", imem_req_addr);
        end else begin
          chk("req_addr", imem_req_addr, exp_req.pop_front());
        end
        hs_total++;
        p_addr = imem_req_addr;
        p_cnt  = lat;
        pend   = 1'b1;
      end
      @(posedge clk);
      #2;
      imem_resp_valid = 1'b0;
      imem_resp_err   = 1'b0;
      if (pend) begin
        p_cnt--;
        if (p_cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = p_addr[31:0] + 32'h1000_0000;
          imem_resp_err   = (p_addr == err_addr);
          pend            = 1'b0;
        end
      end
      imem_req_ready = (hs_total < hs_limit);
    end
  end

  // Decode-side monitor: compares every consumed head against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && inst_valid && inst_ready) begin
        if (exp_inst.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_inst: actual pc=%h required none", inst_pc);
        end else begin
          mon_e = exp_inst.pop_front();
          chk("inst_data", 64'(inst), 64'(mon_e.inst));
          chk("inst_pc", inst_pc, mon_e.pc);
          chk("inst_fault", 64'(inst_fault), 64'(mon_e.fault));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_hs(input int target);
    int n = 0;
    while (hs_total < target && n < 40) begin
      tick(1);
      n++;
    end
    chk("wait_hs", 64'(hs_total), 64'(target));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_req.size() != 0 || exp_inst.size() != 0) && n < 80) begin
      tick(1);
      n++;
    end
    chk("drain_req", 64'(exp_req.size()), 64'd0);
    chk("drain_inst", 64'(exp_inst.size()), 64'd0);
  endtask

  task automatic redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    tick(2);

    // Reset values
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_inst_pc", inst_pc, 64'd0);
    chk("rst_inst_fault", 64'(inst_fault), 64'd0);
    chk("rst_req_addr", imem_req_addr, RST_PC);

    // Streaming fetch, memory always ready, 1-cycle responses
    exp_req.push_back(64'h8000_0000);
    exp_req.push_back(64'h8000_0004);
    exp_req.push_back(64'h8000_0008);
    add_inst(32'h9000_0000, 64'h8000_0000, 2'd0);
    add_inst(32'h9000_0004, 64'h8000_0004, 2'd0);
    add_inst(32'h9000_0008, 64'h8000_0008, 2'd0);
    inst_ready = 1'b1;
    hs_limit   = 3;
    rst_n      = 1'b1;
    wait_drain();

    // Back-pressure: queue fills to 4, requests stop, one pop allows one refill
    inst_ready = 1'b0;
    exp_req.push_back(64'h8000_000C);
    exp_req.push_back(64'h8000_0010);
    exp_req.push_back(64'h8000_0014);
    exp_req.push_back(64'h8000_0018);
    add_inst(32'h9000_000C, 64'h8000_000C, 2'd0);
    add_inst(32'h9000_0010, 64'h8000_0010, 2'd0);
    add_inst(32'h9000_0014, 64'h8000_0014, 2'd0);
    add_inst(32'h9000_0018, 64'h8000_0018, 2'd0);
    hs_limit = hs_total + 4;
    wait_hs(7);
    tick(4);
    chk("full_req_valid", 64'(imem_req_valid), 64'd0);
    chk("full_inst_valid", 64'(inst_valid), 64'd1);
    chk("full_head_pc", inst_pc, 64'h8000_000C);
    hs_limit = hs_total + 10;
    tick(2);
    chk("full_no_req", 64'(imem_req_valid), 64'd0);
    exp_req.push_back(64'h8000_001C);
    add_inst(32'h9000_001C, 64'h8000_001C, 2'd0);
    inst_ready = 1'b1;
    tick(1);
    inst_ready = 1'b0;
    wait_hs(8);
    tick(3);
    chk("refill_stops", 64'(imem_req_valid), 64'd0);
    tick(3);
    chk("one_refill", 64'(hs_total), 64'd8);
    hs_limit   = hs_total;
    inst_ready = 1'b1;
    wait_drain();

    // Redirect during WAIT: in-flight response is dropped
    inst_ready = 1'b0;
    lat        = 2;
    exp_req.push_back(64'h8000_0020);
    hs_limit = hs_total + 1;
    wait_hs(9);
    lat = 1;
    exp_req.push_back(64'h8000_1000);
    add_inst(32'h9000_1000, 64'h8000_1000, 2'd0);
    hs_limit = hs_total + 1;
    redirect(64'h8000_1000);
    chk("redir_wait_empty", 64'(inst_valid), 64'd0);
    wait_hs(10);
    tick(3);
    chk("redir_entry_valid", 64'(inst_valid), 64'd1);
    chk("redir_entry_pc", inst_pc, 64'h8000_1000);

    // Misaligned redirect flushes the queued entry, reports fault 2, halts
    exp_inst.delete();
    add_inst(32'h0, 64'h8000_0202, 2'd2);
    redirect(64'h8000_0202);
    chk("flush_on_redirect", 64'(inst_valid), 64'd0);
    tick(1);
    chk("misalign_valid", 64'(inst_valid), 64'd1);
    chk("misalign_pc", inst_pc, 64'h8000_0202);
    chk("misalign_fault", 64'(inst_fault), 64'd2);
    chk("misalign_no_req", 64'(imem_req_valid), 64'd0);
    hs_limit = hs_total + 5;
    tick(3);
    chk("halt_no_req", 64'(imem_req_valid), 64'd0);
    chk("halt_no_hs", 64'(hs_total), 64'd10);
    inst_ready = 1'b1;
    tick(2);
    inst_ready = 1'b0;
    chk("halt_popped", 64'(inst_valid), 64'd0);
    hs_limit = hs_total + 1;
    exp_req.push_back(64'h8000_0400);
    add_inst(32'h9000_0400, 64'h8000_0400, 2'd0);
    redirect(64'h8000_0400);
    wait_hs(11);
    tick(3);
    chk("resume_valid", 64'(inst_valid), 64'd1);
    chk("resume_pc", inst_pc, 64'h8000_0400);

    // Reset mid-WAIT with a queued entry; late response must be ignored
    lat = 3;
    exp_req.push_back(64'h8000_0404);
    hs_limit = hs_total + 1;
    wait_hs(12);
    rst_n = 1'b0;
    exp_inst.delete();
    #1;
    chk("mid_rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("mid_rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("mid_rst_inst", 64'(inst), 64'd0);
    chk("mid_rst_inst_pc", inst_pc, 64'd0);
    chk("mid_rst_fault", 64'(inst_fault), 64'd0);
    chk("mid_rst_addr", imem_req_addr, RST_PC);
    lat      = 1;
    hs_limit = hs_total;
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Memory not ready for 3 cycles: address held at RESET_PC
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 64'(imem_req_valid), 64'd1);
      chk("stall_addr", imem_req_addr, RST_PC);
      tick(1);
    end
    chk("late_resp_ignored", 64'(inst_valid), 64'd0);

    // Access fault on the second fetch; fetching continues
    err_addr = 64'h8000_0004;
    exp_req.push_back(64'h8000_0000);
    exp_req.push_back(64'h8000_0004);
    exp_req.push_back(64'h8000_0008);
    add_inst(32'h9000_0000, 64'h8000_0000, 2'd0);
    add_inst(32'h9000_0004, 64'h8000_0004, 2'd1);
    add_inst(32'h9000_0008, 64'h8000_0008, 2'd0);
    inst_ready = 1'b1;
    hs_limit   = hs_total + 3;
    wait_drain();
    tick(3);
    chk("final_hs", 64'(hs_total), 64'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
